// File: rtl/stream_mux_rr.sv
// N-channel registered stream mux with valid/ready handshake: fixed-select or round-robin.
// Optional packet lock (channel held until its last beat) enabled by defining MUX_PKT_LOCK_EN.
module stream_mux_rr #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  localparam int unsigned SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode_i,
  input  logic [SEL_W-1:0]          sel_i,
  input  logic [CHANNELS*WIDTH-1:0] in_data_i,
  input  logic [CHANNELS-1:0]       in_valid_i,
`ifdef MUX_PKT_LOCK_EN
  input  logic [CHANNELS-1:0]       in_last_i,
`endif
  output logic [CHANNELS-1:0]       in_ready_o,
  output logic [WIDTH-1:0]          out_data_o,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [SEL_W-1:0]          out_chan_o
`ifdef MUX_PKT_LOCK_EN
  ,
  output logic                      out_last_o
`endif
);

  localparam int unsigned LAST_CH = CHANNELS - 1;

  logic             load_c;
  logic             pick_c;
  logic             xfer_c;
  logic             adv_c;
  logic [SEL_W-1:0] chan_c;
  logic             rr_hit_c;
  logic [SEL_W-1:0] rr_chan_c;
  logic [31:0]      rr_idx_c;

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_chan_q, out_chan_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

`ifdef MUX_PKT_LOCK_EN
  typedef enum logic {ST_IDLE, ST_LOCKED} state_e;
  state_e           state_q, state_d;
  logic [SEL_W-1:0] lk_q, lk_d;
  logic             out_last_q, out_last_d;
  logic             last_c;
`endif

  // First valid channel at or after the round-robin pointer, with wrap.
  always_comb begin
    rr_hit_c  = 1'b0;
    rr_chan_c = '0;
    rr_idx_c  = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      rr_idx_c = 32'(ptr_q) + k;
      if (rr_idx_c >= CHANNELS) rr_idx_c = rr_idx_c - CHANNELS;
      if (!rr_hit_c && in_valid_i[SEL_W'(rr_idx_c)]) begin
        rr_hit_c  = 1'b1;
        rr_chan_c = SEL_W'(rr_idx_c);
      end
    end
  end

  // Channel selection; a locked packet overrides mode and sel.
  always_comb begin
    pick_c = 1'b0;
    chan_c = '0;
`ifdef MUX_PKT_LOCK_EN
    if (state_q == ST_LOCKED) begin
      pick_c = 1'b1;
      chan_c = lk_q;
    end else
`endif
    if (mode_i) begin
      pick_c = rr_hit_c;
      chan_c = rr_chan_c;
    end else begin
      pick_c = (32'(sel_i) < CHANNELS);
      chan_c = sel_i;
    end
  end

  assign load_c = !out_valid_q || out_ready_i;

  always_comb begin
    in_ready_o = '0;
    if (rst_n && load_c && pick_c) in_ready_o[chan_c] = 1'b1;
  end

  assign xfer_c = |(in_ready_o & in_valid_i);

`ifdef MUX_PKT_LOCK_EN
  assign last_c = in_last_i[chan_c];
  assign adv_c  = last_c;
`else
  assign adv_c  = 1'b1;
`endif

  // Output register and pointer next-state.
  always_comb begin
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
`ifdef MUX_PKT_LOCK_EN
    out_last_d  = out_last_q;
`endif
    if (xfer_c) begin
      out_data_d  = in_data_i[32'(chan_c)*WIDTH +: WIDTH];
      out_chan_d  = chan_c;
      out_valid_d = 1'b1;
`ifdef MUX_PKT_LOCK_EN
      out_last_d  = last_c;
`endif
      if (mode_i && adv_c) ptr_d = (32'(chan_c) == LAST_CH) ? '0 : SEL_W'(32'(chan_c) + 32'd1);
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

`ifdef MUX_PKT_LOCK_EN
  // Packet lock: hold the granted channel until it presents its last beat.
  always_comb begin
    state_d = state_q;
    lk_d    = lk_q;
    case (state_q)
      ST_IDLE: begin
        if (xfer_c && !last_c) begin
          state_d = ST_LOCKED;
          lk_d    = chan_c;
        end
      end
      ST_LOCKED: begin
        if (xfer_c && last_c) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      lk_q       <= '0;
      out_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lk_q       <= lk_d;
      out_last_q <= out_last_d;
    end
  end

  assign out_last_o = out_last_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data_o  = out_data_q;
  assign out_chan_o  = out_chan_q;
  assign out_valid_o = out_valid_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr (WIDTH=8, CHANNELS=4): cycle table plus reset and packet-lock sequences.
module tb_stream_mux_rr;

  logic        clk;
  logic        rst_n;
  logic        mode;
  logic [1:0]  sel;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_chan;
`ifdef MUX_PKT_LOCK_EN
  logic [3:0]  in_last;
  logic        out_last;
`endif

  int n_cmp = 0;
  int n_err = 0;

  stream_mux_rr #(.WIDTH(8), .CHANNELS(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mode_i      (mode),
    .sel_i       (sel),
    .in_data_i   (in_data),
    .in_valid_i  (in_valid),
`ifdef MUX_PKT_LOCK_EN
    .in_last_i   (in_last),
    .out_last_o  (out_last),
`endif
    .in_ready_o  (in_ready),
    .out_data_o  (out_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_chan_o  (out_chan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  valid;
    logic [31:0] data;
    logic        ordy;
    logic [3:0]  exp_rdy;
    logic        exp_ov;
    logic [7:0]  exp_od;
    logic [1:0]  exp_oc;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic m, input logic [1:0] s, input logic [3:0] v,
                              input logic [31:0] d, input logic r, input logic [3:0] er,
                              input logic eov, input logic [7:0] eod, input logic [1:0] eoc);
    vec_t t;
    t.mode = m; t.sel = s; t.valid = v; t.data = d; t.ordy = r;
    t.exp_rdy = er; t.exp_ov = eov; t.exp_od = eod; t.exp_oc = eoc;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  localparam logic [31:0] D = 32'hD3C2B1A0;
  localparam logic [31:0] S = 32'h11111111;

  initial begin
    vecs[0]  = mk(1'b0, 2'd2, 4'b0100, 32'hD3A5B1A0, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2);
    vecs[1]  = mk(1'b1, 2'd0, 4'b1111, D, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0);
    vecs[2]  = mk(1'b1, 2'd0, 4'b1111, D, 1'b1, 4'b0010, 1'b1, 8'hB1, 2'd1);
    vecs[3]  = mk(1'b1, 2'd0, 4'b1111, D, 1'b1, 4'b0100, 1'b1, 8'hC2, 2'd2);
    vecs[4]  = mk(1'b1, 2'd0, 4'b1111, D, 1'b1, 4'b1000, 1'b1, 8'hD3, 2'd3);
    vecs[5]  = mk(1'b1, 2'd0, 4'b1111, D, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0);
    vecs[6]  = mk(1'b1, 2'd0, 4'b1111, S, 1'b0, 4'b0000, 1'b1, 8'hA0, 2'd0);
    vecs[7]  = mk(1'b1, 2'd0, 4'b1111, S, 1'b0, 4'b0000, 1'b1, 8'hA0, 2'd0);
    vecs[8]  = mk(1'b1, 2'd0, 4'b1111, S, 1'b0, 4'b0000, 1'b1, 8'hA0, 2'd0);
    vecs[9]  = mk(1'b1, 2'd0, 4'b1111, D, 1'b1, 4'b0010, 1'b1, 8'hB1, 2'd1);
    vecs[10] = mk(1'b1, 2'd0, 4'b1001, D, 1'b1, 4'b1000, 1'b1, 8'hD3, 2'd3);
    vecs[11] = mk(1'b1, 2'd0, 4'b1001, D, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0);
    vecs[12] = mk(1'b1, 2'd0, 4'b1001, D, 1'b1, 4'b1000, 1'b1, 8'hD3, 2'd3);
    vecs[13] = mk(1'b1, 2'd0, 4'b1001, D, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0);
    vecs[14] = mk(1'b0, 2'd1, 4'b1001, D, 1'b1, 4'b0010, 1'b0, 8'hA0, 2'd0);
    vecs[15] = mk(1'b1, 2'd0, 4'b0000, D, 1'b1, 4'b0000, 1'b0, 8'hA0, 2'd0);
    vecs[16] = mk(1'b1, 2'd0, 4'b0100, D, 1'b0, 4'b0100, 1'b1, 8'hC2, 2'd2);
    vecs[17] = mk(1'b0, 2'd0, 4'b0001, D, 1'b0, 4'b0000, 1'b1, 8'hC2, 2'd2);
    vecs[18] = mk(1'b0, 2'd0, 4'b0001, D, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0);
    vecs[19] = mk(1'b1, 2'd0, 4'b1111, D, 1'b1, 4'b1000, 1'b1, 8'hD3, 2'd3);
    vecs[20] = mk(1'b0, 2'd3, 4'b1000, D, 1'b1, 4'b1000, 1'b1, 8'hD3, 2'd3);

    rst_n     = 1'b0;
    mode      = 1'b1;
    sel       = 2'd0;
    in_data   = D;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
`ifdef MUX_PKT_LOCK_EN
    in_last   = 4'b1111;
`endif
    #3;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_data", 32'(out_data), 32'd0);
    check("reset out_chan", 32'(out_chan), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd0);
`ifdef MUX_PKT_LOCK_EN
    check("reset out_last", 32'(out_last), 32'd0);
`endif
    @(negedge clk);
    in_valid = 4'b0000;
    rst_n    = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      mode      = vecs[i].mode;
      sel       = vecs[i].sel;
      in_valid  = vecs[i].valid;
      in_data   = vecs[i].data;
      out_ready = vecs[i].ordy;
      #1;
      check($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
      @(posedge clk);
      #1;
      check($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
      check($sformatf("v%0d out_data", i), 32'(out_data), 32'(vecs[i].exp_od));
      check($sformatf("v%0d out_chan", i), 32'(out_chan), 32'(vecs[i].exp_oc));
    end

    // Grant ch0 so ptr moves off zero, then reset asynchronously mid-stream.
    @(negedge clk);
    mode = 1'b1; in_valid = 4'b1111; in_data = D; out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("pre-reset out_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset out_valid", 32'(out_valid), 32'd0);
    check("async reset out_data", 32'(out_data), 32'd0);
    check("async reset in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post-reset in_ready", 32'(in_ready), 32'b0001);
    @(posedge clk);
    #1;
    check("post-reset out_chan", 32'(out_chan), 32'd0);
    check("post-reset out_data", 32'(out_data), 32'hA0);

`ifdef MUX_PKT_LOCK_EN
    // ptr=1 now; ch1 sends a 3-beat packet while ch0 stays valid.
    begin
      logic [3:0] lasts [4];
      logic [1:0] exp_ch [4];
      logic       exp_lst [4];
      lasts[0] = 4'b0001; lasts[1] = 4'b0001; lasts[2] = 4'b0011; lasts[3] = 4'b0011;
      exp_ch[0] = 2'd1; exp_ch[1] = 2'd1; exp_ch[2] = 2'd1; exp_ch[3] = 2'd0;
      exp_lst[0] = 1'b0; exp_lst[1] = 1'b0; exp_lst[2] = 1'b1; exp_lst[3] = 1'b1;
      for (int b = 0; b < 4; b++) begin
        @(negedge clk);
        in_last  = lasts[b];
        mode     = (b == 1) ? 1'b0 : 1'b1;
        sel      = (b == 1) ? 2'd3 : 2'd0;
        in_valid = (b == 1) ? 4'b1011 : 4'b0011;
        @(posedge clk);
        #1;
        check($sformatf("lock b%0d out_chan", b), 32'(out_chan), 32'(exp_ch[b]));
        check($sformatf("lock b%0d out_last", b), 32'(out_last), 32'(exp_lst[b]));
        check($sformatf("lock b%0d out_valid", b), 32'(out_valid), 32'd1);
      end
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
